// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_ctrl
// Description : Serialises valid/ready words MSB-first and runs a programmable
//               (1..8 bit, overlap-selectable) pattern match with a saturating
//               match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl #(
    parameter int         W       = 8,
    parameter int         CW      = 8,
    parameter logic [7:0] RST_PAT = 8'b0001_0100,
    parameter int         RST_LEN = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [7:0]    cfg_pattern,
    input  logic [3:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic          clr_cnt,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          ser_bit,
    output logic          ser_valid,
    output logic          match,
    output logic [CW-1:0] match_cnt,
    output logic          busy,
    output logic          done
);
    localparam int            c_iw       = $clog2(W);
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(W - 1);
    localparam logic [3:0]    c_rst_len  = (RST_LEN < 1) ? 4'd1 :
                                           (RST_LEN > 8) ? 4'd8 : 4'(RST_LEN);
    localparam logic [CW-1:0] c_cnt_max  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_word;
    logic [c_iw-1:0] r_idx;
    logic [7:0]      r_hist;
    logic [3:0]      r_hcnt;
    logic [7:0]      r_pat;
    logic [3:0]      r_len;
    logic            r_ovl;

    logic [7:0]      w_hist_nxt;
    logic [3:0]      w_hcnt_nxt;
    logic [8:0]      w_mask_full;
    logic [7:0]      w_mask;
    logic            w_match;
    logic [3:0]      w_len_clamp;

    always_comb begin
        w_hist_nxt  = {r_hist[6:0], r_word[W-1]};
        w_hcnt_nxt  = (r_hcnt == 4'd8) ? 4'd8 : r_hcnt + 4'd1;
        w_mask_full = (9'd1 << r_len) - 9'd1;
        w_mask      = w_mask_full[7:0];
        w_match     = (w_hcnt_nxt >= r_len) &&
                      ((w_hist_nxt & w_mask) == (r_pat & w_mask));
        w_len_clamp = (cfg_len == 4'd0) ? 4'd1 :
                      (cfg_len > 4'd8)  ? 4'd8 : cfg_len;
    end

    // The word register shifts left so its MSB is always the bit on the wire.
    assign ser_bit   = r_word[W-1];
    assign ser_valid = (r_state == S_SHIFT);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign in_ready  = (r_state == S_IDLE) && !cfg_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_idx     <= '0;
            r_hist    <= '0;
            r_hcnt    <= '0;
            r_pat     <= RST_PAT;
            r_len     <= c_rst_len;
            r_ovl     <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_pat  <= cfg_pattern;
                        r_len  <= w_len_clamp;
                        r_ovl  <= cfg_overlap;
                        r_hist <= '0;
                        r_hcnt <= '0;
                    end else if (in_valid) begin
                        r_word  <= in_data;
                        r_idx   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_word <= r_word << 1;
                    r_hist <= w_hist_nxt;
                    // Non-overlap mode restarts the fill count after a hit.
                    r_hcnt <= (w_match && !r_ovl) ? 4'd0 : w_hcnt_nxt;
                    match  <= w_match;
                    r_idx  <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (clr_cnt) begin
                match_cnt <= '0;
            end else if ((r_state == S_SHIFT) && w_match && (match_cnt != c_cnt_max)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_ctrl
// Description : Directed and random stimulus for pattern_scan_ctrl against a
//               bit-history reference model; a CW=2 copy checks saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, cfg_we, cfg_overlap, clr_cnt, in_valid;
    logic [7:0]   cfg_pattern;
    logic [3:0]   cfg_len;
    logic [W-1:0] in_data;
    logic         in_ready, ser_bit, ser_valid, match, busy, done;
    logic [7:0]   match_cnt;
    logic         in_ready2, ser_bit2, ser_valid2, match2, busy2, done2;
    logic [1:0]   match_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: configuration, recent serial bits, fresh-bit count.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         hq[$];
    int         fresh;
    int         cnt, cnt2;
    bit         rand_clr;

    pattern_scan_ctrl #(.W(W), .CW(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .match(match),
        .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    pattern_scan_ctrl #(.W(W), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .ser_bit(ser_bit2), .ser_valid(ser_valid2), .match(match2),
        .match_cnt(match_cnt2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_cfg(input logic [7:0] pat, input int len, input bit ovl);
        m_pat = pat;
        m_len = (len == 0) ? 1 : (len > 8) ? 8 : len;
        m_ovl = ovl;
        hq.delete();
        fresh = 0;
    endfunction

    function automatic bit model_bit(input bit b);
        bit hit;
        hq.push_back(b);
        if (hq.size() > 8) void'(hq.pop_front());
        fresh = (fresh >= 8) ? 8 : fresh + 1;
        hit = (fresh >= m_len);
        if (hit) begin
            for (int i = 0; i < m_len; i++) begin
                if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
        end
        if (hit && !m_ovl) fresh = 0;
        return hit;
    endfunction

    // Advance one clock; m_reg is the match the model expects registered at this edge.
    task automatic tick(input bit m_reg);
        if (rst || clr_cnt) begin
            cnt  = 0;
            cnt2 = 0;
        end else if (m_reg) begin
            if (cnt < 255) cnt++;
            if (cnt2 < 3) cnt2++;
        end
        @(posedge clk);
        #1;
        chk("match_cnt", match_cnt, cnt);
        chk("match_cnt_cw2", match_cnt2, cnt2);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_match"}, match, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        #1;
        chk("cfg_in_ready", in_ready, 0);
        tick(1'b0);
        cfg_we = 1'b0;
        model_cfg(pat, int'(len), ovl);
    endtask

    task automatic clear_count();
        clr_cnt = 1'b1;
        tick(1'b0);
        clr_cnt = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] data, input bit hold, input bit poke, input int clr_k);
        bit m[W];
        int waitc;
        in_valid = 1'b1;
        in_data  = data;
        waitc    = 0;
        while (in_ready !== 1'b1) begin
            if (waitc++ > 40) begin
                chk("accept_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            tick(1'b0);
        end
        for (int k = 0; k < W; k++) m[k] = model_bit(data[W-1-k]);
        tick(1'b0);
        if (!hold) in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("shift_ser_valid", ser_valid, 1);
            chk("shift_ser_bit", ser_bit, data[W-1-k]);
            chk("shift_in_ready", in_ready, 0);
            chk("shift_busy", busy, 1);
            chk("shift_done", done, 0);
            chk("shift_match", match, (k == 0) ? 1'b0 : m[k-1]);
            cfg_we = poke && (k == 2);
            if (cfg_we) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = 4'($urandom);
                cfg_overlap = 1'($urandom);
            end
            clr_cnt = (k == clr_k) || (rand_clr && ($urandom_range(0, 15) == 0));
            tick(m[k]);
            cfg_we  = 1'b0;
            clr_cnt = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_ser_valid", ser_valid, 0);
        chk("done_in_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_match", match, m[W-1]);
        tick(1'b0);
        check_idle("post_word");
    endtask

    task automatic reset_mid_shift(input logic [W-1:0] data);
        bit mb;
        in_valid = 1'b1;
        in_data  = data;
        chk("mr_in_ready", in_ready, 1);
        tick(1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mr_ser_bit", ser_bit, data[W-1-k]);
            mb = model_bit(data[W-1-k]);
            tick(mb);
        end
        chk("mr_k3_busy", busy, 1);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        model_cfg(8'b0001_0100, 5, 1'b0);
        check_idle("mr_after_rst");
        tick(1'b0);
        check_idle("mr_no_done");
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        clr_cnt = 1'b0; in_valid = 1'b0; in_data = '0;
        rand_clr = 1'b0; cnt = 0; cnt2 = 0;
        model_cfg(8'b0001_0100, 5, 1'b0);
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        check_idle("reset");
        chk("reset_ser_bit", ser_bit, 0);

        send_word(8'b1010_0000, 1'b0, 1'b0, -1);
        chk("default_word_cnt", match_cnt, 1);

        configure(8'b101, 4'd3, 1'b1);
        clear_count();
        send_word(8'b1010_1010, 1'b0, 1'b0, -1);
        chk("overlap_cnt", match_cnt, 3);

        configure(8'b101, 4'd3, 1'b0);
        clear_count();
        send_word(8'b1010_1010, 1'b0, 1'b0, -1);
        chk("nonoverlap_cnt", match_cnt, 2);

        configure(8'b0001_0100, 4'd5, 1'b0);
        clear_count();
        send_word(8'b0000_0101, 1'b0, 1'b0, -1);
        send_word(8'b0000_0000, 1'b0, 1'b0, -1);
        chk("boundary_cnt", match_cnt, 1);

        // Producer keeps in_valid high; config pokes during SHIFT must be ignored.
        send_word(8'b1010_0000, 1'b1, 1'b1, -1);
        send_word(8'b0011_1100, 1'b1, 1'b1, -1);
        send_word(8'b0101_0000, 1'b1, 1'b0, -1);
        in_valid = 1'b0;
        tick(1'b0);
        check_idle("bp_no_reaccept");

        reset_mid_shift(8'b1010_0101);
        send_word(8'b1010_0000, 1'b0, 1'b0, -1);
        chk("post_reset_cnt", match_cnt, 1);

        configure(8'b1, 4'd1, 1'b1);
        clear_count();
        send_word(8'hFF, 1'b0, 1'b0, -1);
        chk("cw2_saturate", match_cnt2, 3);
        chk("ff_cnt", match_cnt, 8);
        send_word(8'hFF, 1'b0, 1'b0, 5);
        chk("clr_wins_cnt", match_cnt, 2);
        for (int i = 0; i < 32; i++) send_word(8'hFF, 1'b0, 1'b0, -1);
        chk("cw8_saturate", match_cnt, 255);

        rand_clr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                configure(8'($urandom), 4'($urandom), 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick(1'b0);
            send_word(W'($urandom), 1'($urandom), 1'($urandom), -1);
            in_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
